// File: rtl/fp_round_int.sv
// fp_round_int -- rounds an IEEE-754 binary value (any width) to an integral
// value in the same format, with a per-operation rounding mode.
// Two-stage pipeline with valid/ready handshaking on both sides.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   input handshake (in_ready is combinational)
//   i                     operand (FPWID bits)
//   rm                    rounding mode: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM, 5-7 RTZ
//   in_tag                opaque tag, returned with the result
//   out_valid / out_ready output handshake
//   o                     rounded result
//   out_tag               tag of the result
//   inexact               discarded fraction bits were nonzero
//   invalid               operand was a signalling NaN
module fp_round_int #(
  parameter int FPWID  = 32,
  parameter int EXPWID = 8,
  parameter int TAGW   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FPWID-1:0]  i,
  input  logic [2:0]        rm,
  input  logic [TAGW-1:0]   in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FPWID-1:0]  o,
  output logic [TAGW-1:0]   out_tag,
  output logic              inexact,
  output logic              invalid
);

  localparam int FW = FPWID - EXPWID - 1;
  localparam int BIAS = (1 << (EXPWID - 1)) - 1;
  localparam int MW = EXPWID + FW;

  localparam logic [31:0]       HUGE_EXP = 32'(BIAS + FW);
  localparam logic [EXPWID-1:0] BIAS_EXP = {1'b0, {(EXPWID-1){1'b1}}};
  localparam logic [FW-1:0]     SIG_ONES = '1;
  localparam logic [FW-1:0]     QBIT     = {1'b1, {(FW-1){1'b0}}};
  localparam logic [FW:0]       LSB_ONE  = {{FW{1'b0}}, 1'b1};
  localparam logic [MW-1:0]     MAG_ONE  = {{(MW-1){1'b0}}, 1'b1};
  localparam logic [MW-1:0]     ONE_MAG  = {BIAS_EXP, {FW{1'b0}}};

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } rm_e;

  // Handshake
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic s2_adv, accept;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_adv;
  assign accept   = in_valid && in_ready;

  // Stage 1 registers
  logic              s1_sign_q, s1_sign_d;
  logic [EXPWID-1:0] s1_exp_q,  s1_exp_d;
  logic [FW-1:0]     s1_sig_q,  s1_sig_d;
  rm_e               s1_rm_q,   s1_rm_d;
  logic [TAGW-1:0]   s1_tag_q,  s1_tag_d;
  rm_e               rm_in;

  // Stage 2 (output) registers
  logic [FPWID-1:0]  o_q, o_d;
  logic [TAGW-1:0]   tag_q, tag_d;
  logic              inexact_q, inexact_d;
  logic              invalid_q, invalid_d;

  always_comb begin
    rm_in = RM_RTZ;
    case (rm)
      3'd0:    rm_in = RM_RNE;
      3'd2:    rm_in = RM_RDN;
      3'd3:    rm_in = RM_RUP;
      3'd4:    rm_in = RM_RMM;
      default: rm_in = RM_RTZ;
    endcase
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_exp_d   = s1_exp_q;
    s1_sig_d   = s1_sig_q;
    s1_rm_d    = s1_rm_q;
    s1_tag_d   = s1_tag_q;
    if (in_ready) s1_valid_d = in_valid;
    if (accept) begin
      s1_sign_d = i[FPWID-1];
      s1_exp_d  = i[FPWID-2:FW];
      s1_sig_d  = i[FW-1:0];
      s1_rm_d   = rm_in;
      s1_tag_d  = in_tag;
    end
  end

  // Classification of the stage-1 operand
  logic [31:0]   exp_w;
  logic [31:0]   k;
  logic          is_special, is_huge, is_small, is_zero, sig_nz;
  logic [FW-1:0] frac_mask;
  logic          round_bit, sticky, lsb;
  logic [MW-1:0] trunc_mag, rounded_mag;
  logic          mid_inc, small_up;

  assign exp_w      = 32'(s1_exp_q);
  assign sig_nz     = |s1_sig_q;
  assign is_special = &s1_exp_q;
  assign is_huge    = exp_w >= HUGE_EXP;
  assign is_small   = s1_exp_q < BIAS_EXP;
  assign is_zero    = (s1_exp_q == '0) && !sig_nz;

  // k = number of fraction bits below the binary point (1..FW for mid values)
  assign k         = HUGE_EXP - exp_w;
  assign frac_mask = ~(SIG_ONES << k);
  // top bit of the mask is the round bit, the rest feed sticky
  assign round_bit = |(s1_sig_q & frac_mask & ~(frac_mask >> 1));
  assign sticky    = |(s1_sig_q & (frac_mask >> 1));
  assign lsb       = |({1'b1, s1_sig_q} & (LSB_ONE << k));

  // Adding at bit k of {exp,sig} lets a significand carry bump the exponent
  assign trunc_mag   = {s1_exp_q, s1_sig_q} & ~{{EXPWID{1'b0}}, frac_mask};
  assign rounded_mag = trunc_mag + (mid_inc ? (MAG_ONE << k) : '0);

  always_comb begin
    mid_inc  = 1'b0;
    small_up = 1'b0;
    case (s1_rm_q)
      RM_RNE: begin
        mid_inc  = round_bit && (sticky || lsb);
        small_up = (s1_exp_q == BIAS_EXP - 1'b1) && sig_nz;
      end
      RM_RDN: begin
        mid_inc  = s1_sign_q && (round_bit || sticky);
        small_up = s1_sign_q;
      end
      RM_RUP: begin
        mid_inc  = !s1_sign_q && (round_bit || sticky);
        small_up = !s1_sign_q;
      end
      RM_RMM: begin
        mid_inc  = round_bit;
        small_up = (s1_exp_q == BIAS_EXP - 1'b1);
      end
      default: begin
        mid_inc  = 1'b0;
        small_up = 1'b0;
      end
    endcase
  end

  logic [FPWID-1:0] res;
  logic             res_inexact, res_invalid;

  always_comb begin
    res         = {s1_sign_q, s1_exp_q, s1_sig_q};
    res_inexact = 1'b0;
    res_invalid = 1'b0;
    if (is_special) begin
      if (sig_nz) begin
        res         = {s1_sign_q, s1_exp_q, s1_sig_q | QBIT};
        res_invalid = !s1_sig_q[FW-1];
      end
    end else if (!(is_huge || is_zero)) begin
      if (is_small) begin
        res_inexact = 1'b1;
        res         = small_up ? {s1_sign_q, ONE_MAG} : {s1_sign_q, {MW{1'b0}}};
      end else begin
        res_inexact = round_bit || sticky;
        res         = {s1_sign_q, rounded_mag};
      end
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    o_d        = o_q;
    tag_d      = tag_q;
    inexact_d  = inexact_q;
    invalid_d  = invalid_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        o_d       = res;
        tag_d     = s1_tag_q;
        inexact_d = res_inexact;
        invalid_d = res_invalid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_exp_q   <= '0;
      s1_sig_q   <= '0;
      s1_rm_q    <= RM_RTZ;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      o_q        <= '0;
      tag_q      <= '0;
      inexact_q  <= 1'b0;
      invalid_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sign_q  <= s1_sign_d;
      s1_exp_q   <= s1_exp_d;
      s1_sig_q   <= s1_sig_d;
      s1_rm_q    <= s1_rm_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      o_q        <= o_d;
      tag_q      <= tag_d;
      inexact_q  <= inexact_d;
      invalid_q  <= invalid_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign o         = o_q;
  assign out_tag   = tag_q;
  assign inexact   = inexact_q;
  assign invalid   = invalid_q;

endmodule

// File: tb/tb_fp_round_int.sv
// tb_fp_round_int -- scoreboard bench for fp_round_int (32-bit instance plus a
// 64-bit instance). Expected results are queued when an operation is accepted
// and popped by an independent monitor whenever a result transfers out.
module tb_fp_round_int;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] i, o;
  logic [2:0]  rm;
  logic [3:0]  in_tag, out_tag;
  logic        inexact, invalid;

  logic        in_valid64, in_ready64, out_valid64;
  logic [63:0] i64, o64;
  logic [3:0]  out_tag64;
  logic        inexact64, invalid64;

  fp_round_int #(.FPWID(32), .EXPWID(8), .TAGW(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .i(i), .rm(rm),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .o(o),
    .out_tag(out_tag), .inexact(inexact), .invalid(invalid)
  );

  fp_round_int #(.FPWID(64), .EXPWID(11), .TAGW(4)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid64), .in_ready(in_ready64), .i(i64),
    .rm(3'd0), .in_tag(4'd0), .out_valid(out_valid64), .out_ready(1'b1), .o(o64),
    .out_tag(out_tag64), .inexact(inexact64), .invalid(invalid64)
  );

  typedef struct {
    logic [31:0] o;
    logic [3:0]  tag;
    logic        inx;
    logic        inv;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  logic bp_random = 1'b0;

  function automatic exp_t mk(input logic [31:0] r, input logic [3:0] t, input logic x, input logic v);
    exp_t e;
    e.o = r; e.tag = t; e.inx = x; e.inv = v;
    return e;
  endfunction

  // Reference: take the integer part q of |x| and compare the discarded
  // remainder against one half, then re-encode the integer as a float.
  function automatic void ref_round(input logic [31:0] a, input logic [2:0] m,
                                    output logic [31:0] r, output logic inx, output logic inv);
    logic sign;
    logic [7:0] ex;
    logic [22:0] fr;
    longint unsigned full, q, rem, half;
    int k, p, mode;
    logic gt, eq, nz, up;
    sign = a[31]; ex = a[30:23]; fr = a[22:0];
    mode = (m > 3'd4) ? 1 : int'(m);
    r = a; inx = 1'b0; inv = 1'b0;
    if (ex == 8'hFF) begin
      if (fr != 0) begin r = a | 32'h0040_0000; inv = !a[22]; end
    end else if ((ex == 0 && fr == 0) || ex >= 150) begin
      r = a;
    end else begin
      if (ex < 127) begin
        q = 0; nz = 1'b1;
        gt = (ex == 126) && (fr != 0);
        eq = (ex == 126) && (fr == 0);
      end else begin
        k = 150 - int'(ex);
        full = {40'd0, 1'b1, fr};
        q = full >> k;
        rem = full - (q << k);
        half = 64'd1 << (k - 1);
        gt = rem > half; eq = rem == half; nz = rem != 0;
      end
      case (mode)
        0: up = gt || (eq && q[0]);
        2: up = sign && nz;
        3: up = !sign && nz;
        4: up = gt || eq;
        default: up = 1'b0;
      endcase
      q = q + (up ? 64'd1 : 64'd0);
      inx = nz;
      if (q == 0) r = {sign, 31'd0};
      else begin
        p = 0;
        for (int b = 0; b < 64; b++) if (q[b]) p = b;
        r = {sign, 8'(127 + p), 23'(q << (23 - p))};
      end
    end
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Offer one operation; the expected response is queued at acceptance.
  task automatic send(input logic [31:0] op, input logic [2:0] m, input logic [3:0] tag,
                      input exp_t e, output int waited);
    logic done;
    done = 1'b0; waited = 0;
    in_valid = 1'b1; i = op; rm = m; in_tag = tag;
    while (!done && waited < 64) begin
      @(negedge clk);
      if (in_ready) begin sb.push_back(e); done = 1'b1; end
      @(posedge clk); #1;
      if (!done) waited++;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++; failures++;
      $display("FAIL accept_timeout tag=%0d in_ready=0 for 64 cycles, required 1", tag);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
    if (sb.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout pending=%0d required 0", sb.size());
    end
  endtask

  // Monitor: pop/compare on each output transfer, check hold while stalled.
  logic        held_valid = 1'b0;
  logic [37:0] held;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) held_valid = 1'b0;
      else if (out_valid) begin
        if (held_valid) begin
          checks++;
          if ({o, out_tag, inexact, invalid} !== held) begin
            failures++;
            $display("FAIL hold_stable o=%h tag=%0d inexact=%0d invalid=%0d required {o,tag,flags}=%h",
                     o, out_tag, inexact, invalid, held);
          end
        end
        if (out_ready) begin
          checks++;
          held_valid = 1'b0;
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_output o=%h tag=%0d required no output", o, out_tag);
          end else begin
            e = sb.pop_front();
            if (o !== e.o || out_tag !== e.tag || inexact !== e.inx || invalid !== e.inv) begin
              failures++;
              $display("FAIL result o=%h tag=%0d inexact=%0d invalid=%0d required o=%h tag=%0d inexact=%0d invalid=%0d",
                       o, out_tag, inexact, invalid, e.o, e.tag, e.inx, e.inv);
            end
          end
        end else begin
          held_valid = 1'b1;
          held = {o, out_tag, inexact, invalid};
        end
      end else held_valid = 1'b0;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (bp_random) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  localparam int ND = 25;
  logic [2:0]  d_rm [ND] = '{3'd0, 3'd4, 3'd1, 3'd2, 3'd3, 3'd0, 3'd4, 3'd2, 3'd3, 3'd1,
                            3'd0, 3'd4, 3'd3, 3'd2, 3'd0, 3'd2, 3'd6, 3'd0, 3'd3, 3'd3,
                            3'd0, 3'd5, 3'd2, 3'd7, 3'd0};
  logic [31:0] d_op [ND] = '{32'h40200000, 32'h40200000, 32'h40200000, 32'hBE99999A, 32'hBE99999A,
                            32'hBE99999A, 32'h80000000, 32'h80000000, 32'h3FFFFFFF, 32'h3FFFFFFF,
                            32'h3F000000, 32'h3F000000, 32'h4B800000, 32'h4B800000, 32'h7F800001,
                            32'hFF800000, 32'h40600000, 32'h40600000, 32'hC0200000, 32'h00000001,
                            32'h3F800000, 32'h7FC00000, 32'h3FC00000, 32'hBFC00000, 32'h4AFFFFFF};
  logic [31:0] d_res [ND] = '{32'h40000000, 32'h40400000, 32'h40000000, 32'hBF800000, 32'h80000000,
                             32'h80000000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h3F800000,
                             32'h00000000, 32'h3F800000, 32'h4B800000, 32'h4B800000, 32'h7FC00001,
                             32'hFF800000, 32'h40400000, 32'h40800000, 32'hC0000000, 32'h3F800000,
                             32'h3F800000, 32'h7FC00000, 32'h3F800000, 32'hBF800000, 32'h4B000000};
  logic        d_inx [ND] = '{1, 1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1, 1};
  logic        d_inv [ND] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

  initial begin
    int w, n;
    logic [31:0] op, r;
    logic [22:0] fr, one23;
    logic [7:0]  ex;
    logic [2:0]  m;
    logic        x, v;
    one23 = 23'd1;
    rst = 1'b1; in_valid = 1'b0; i = '0; rm = '0; in_tag = '0; out_ready = 1'b1;
    in_valid64 = 1'b0; i64 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_o", 64'(o), 64'd0);
    chk("reset_out_tag", 64'(out_tag), 64'd0);
    chk("reset_inexact", 64'(inexact), 64'd0);
    chk("reset_invalid", 64'(invalid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // 64-bit format: 2.5 under RNE
    in_valid64 = 1'b1; i64 = 64'h4004000000000000;
    @(posedge clk); #1 in_valid64 = 1'b0;
    n = 0;
    while (!out_valid64 && n < 10) begin @(negedge clk); n++; end
    chk("fp64_out_valid", 64'(out_valid64), 64'd1);
    chk("fp64_o", o64, 64'h4000000000000000);
    chk("fp64_inexact", 64'(inexact64), 64'd1);
    @(posedge clk); #1;

    // Directed vectors, back to back
    for (int d = 0; d < ND; d++)
      send(d_op[d], d_rm[d], 4'(d), mk(d_res[d], 4'(d), d_inx[d], d_inv[d]), w);
    drain();

    // Backpressure: two accepted, third refused while stalled
    out_ready = 1'b0;
    ref_round(32'h40200000, 3'd0, r, x, v);
    send(32'h40200000, 3'd0, 4'd1, mk(r, 4'd1, x, v), w);
    chk("bp_accept1_wait", 64'(w), 64'd0);
    ref_round(32'hBE99999A, 3'd2, r, x, v);
    send(32'hBE99999A, 3'd2, 4'd2, mk(r, 4'd2, x, v), w);
    chk("bp_accept2_wait", 64'(w), 64'd0);
    in_valid = 1'b1; i = 32'h3FFFFFFF; rm = 3'd3; in_tag = 4'd3;
    @(negedge clk);
    chk("bp_third_in_ready", 64'(in_ready), 64'd0);
    repeat (2) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    ref_round(32'h3FFFFFFF, 3'd3, r, x, v);
    send(32'h3FFFFFFF, 3'd3, 4'd3, mk(r, 4'd3, x, v), w);
    drain();

    // Reset with two operations in flight
    out_ready = 1'b0;
    send(32'h40600000, 3'd0, 4'd5, mk(32'h40800000, 4'd5, 1'b1, 1'b0), w);
    send(32'h40600000, 3'd1, 4'd6, mk(32'h40400000, 4'd6, 1'b1, 1'b0), w);
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1 out_ready = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    chk("flush_no_stale", 64'(out_valid), 64'd0);
    send(32'h40200000, 3'd4, 4'd7, mk(32'h40400000, 4'd7, 1'b1, 1'b0), w);
    drain();

    // Randomized operands, modes, gaps and backpressure
    bp_random = 1'b1;
    for (int t = 0; t < 400; t++) begin
      case ($urandom_range(0, 9))
        0: ex = 8'hFF;
        1: ex = 8'h00;
        2: ex = 8'd126;
        3: ex = 8'($urandom_range(150, 254));
        default: ex = 8'($urandom_range(118, 152));
      endcase
      fr = 23'($urandom);
      if ($urandom_range(0, 1) == 1) fr = fr & ~((one23 << $urandom_range(0, 23)) - one23);
      op = {1'($urandom_range(0, 1)), ex, fr};
      m = 3'($urandom_range(0, 7));
      ref_round(op, m, r, x, v);
      send(op, m, 4'(t), mk(r, 4'(t), x, v), w);
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    bp_random = 1'b0;
    out_ready = 1'b1;
    drain();
    repeat (4) begin @(posedge clk); #1; end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
